// File: rtl/ex_wb_return_pkg.sv
// Shared widths and the MEM/WB stage payload for the EX->ID return path.
package ex_wb_return_pkg;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam logic [AW-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } stage_t;

endpackage

// File: rtl/ex_wb_return_fwd_mux.sv
// One operand's forwarding select: MEM hit beats WB hit, register 0 never forwards.
module ex_wb_return_fwd_mux
  import ex_wb_return_pkg::*;
(
  input  logic [AW-1:0] raddr,
  input  logic [DW-1:0] rdata,
  input  stage_t        mem,
  input  stage_t        wb,
  output logic [DW-1:0] fwd_c,
  output logic          hit_c
);

  always_comb begin
    fwd_c = rdata;
    hit_c = 1'b0;
    if (raddr != REG_ZERO) begin
      if (mem.we && (mem.addr == raddr)) begin
        fwd_c = mem.data;
        hit_c = 1'b1;
      end else if (wb.we && (wb.addr == raddr)) begin
        fwd_c = wb.data;
        hit_c = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ex_wb_return.sv
// EX result return path: MEM/WB staging, register-file write port and ID operand forwarding.
// Optional macro FWD_COUNT_EN adds a saturating 16-bit forwarding event counter (fwd_count).
module ex_wb_return
  import ex_wb_return_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          EX_RegDst,
  input  logic          EX_RegWrite,
  input  logic [AW-1:0] EX_rt,
  input  logic [AW-1:0] EX_rd,
  input  logic [DW-1:0] EX_result,
  input  logic          hold,
  input  logic          flush,
  input  logic [AW-1:0] ID_rs,
  input  logic [AW-1:0] ID_rt,
  input  logic [DW-1:0] ID_rdata1,
  input  logic [DW-1:0] ID_rdata2,
  output logic          WB_RegWrite,
  output logic [AW-1:0] WB_waddr,
  output logic [DW-1:0] WB_wdata,
  output logic [DW-1:0] ID_rdata1_fwd,
  output logic [DW-1:0] ID_rdata2_fwd
`ifdef FWD_COUNT_EN
  ,
  output logic [15:0]   fwd_count
`endif
);

  stage_t        ex_c;
  stage_t        mem_q;
  stage_t        wb_q;
  logic [AW-1:0] dst_c;
  logic          hit1_c;
  logic          hit2_c;

  // Writes to register 0 are dropped here so nothing downstream needs to re-check.
  always_comb begin
    dst_c   = EX_RegDst ? EX_rd : EX_rt;
    ex_c.we   = EX_RegWrite && (dst_c != REG_ZERO);
    ex_c.addr = dst_c;
    ex_c.data = EX_result;
  end

  // Flush wins over hold on MEM so a held pipeline can still drop the squashed result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '0;
    end else if (flush) begin
      mem_q <= '0;
    end else if (!hold) begin
      mem_q <= ex_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_q <= '0;
    end else if (!hold) begin
      wb_q <= mem_q;
    end
  end

  assign WB_RegWrite = wb_q.we;
  assign WB_waddr    = wb_q.addr;
  assign WB_wdata    = wb_q.data;

  ex_wb_return_fwd_mux u_fwd_rs (
    .raddr (ID_rs),
    .rdata (ID_rdata1),
    .mem   (mem_q),
    .wb    (wb_q),
    .fwd_c (ID_rdata1_fwd),
    .hit_c (hit1_c)
  );

  ex_wb_return_fwd_mux u_fwd_rt (
    .raddr (ID_rt),
    .rdata (ID_rdata2),
    .mem   (mem_q),
    .wb    (wb_q),
    .fwd_c (ID_rdata2_fwd),
    .hit_c (hit2_c)
  );

`ifdef FWD_COUNT_EN
  // At most one count per unheld edge, saturating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_count <= 16'd0;
    end else if (!hold && (hit1_c || hit2_c) && (fwd_count != 16'hFFFF)) begin
      fwd_count <= fwd_count + 16'd1;
    end
  end
`else
  logic unused_hit;
  assign unused_hit = hit1_c ^ hit2_c;
`endif

endmodule

// File: tb/tb_ex_wb_return.sv
// Self-checking bench for ex_wb_return against an in-flight-results reference model.
module tb_ex_wb_return;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          EX_RegDst, EX_RegWrite, hold, flush;
  logic [AW-1:0] EX_rt, EX_rd, ID_rs, ID_rt;
  logic [DW-1:0] EX_result, ID_rdata1, ID_rdata2;
  logic          WB_RegWrite;
  logic [AW-1:0] WB_waddr;
  logic [DW-1:0] WB_wdata, ID_rdata1_fwd, ID_rdata2_fwd;
`ifdef FWD_COUNT_EN
  logic [15:0]   fwd_count;
`endif

  int total = 0;
  int bad   = 0;

  // In-flight results, index 0 = newest (MEM), index 1 = oldest (WB).
  logic          m_we   [2];
  logic [AW-1:0] m_addr [2];
  logic [DW-1:0] m_data [2];
  int unsigned   m_cnt;

  always #5 clk = ~clk;

  ex_wb_return dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .EX_RegDst     (EX_RegDst),
    .EX_RegWrite   (EX_RegWrite),
    .EX_rt         (EX_rt),
    .EX_rd         (EX_rd),
    .EX_result     (EX_result),
    .hold          (hold),
    .flush         (flush),
    .ID_rs         (ID_rs),
    .ID_rt         (ID_rt),
    .ID_rdata1     (ID_rdata1),
    .ID_rdata2     (ID_rdata2),
    .WB_RegWrite   (WB_RegWrite),
    .WB_waddr      (WB_waddr),
    .WB_wdata      (WB_wdata),
    .ID_rdata1_fwd (ID_rdata1_fwd),
    .ID_rdata2_fwd (ID_rdata2_fwd)
`ifdef FWD_COUNT_EN
    ,
    .fwd_count     (fwd_count)
`endif
  );

  function automatic logic [DW-1:0] exp_fwd(input logic [AW-1:0] a, input logic [DW-1:0] raw);
    if (a == 0) return raw;
    for (int i = 0; i < 2; i++)
      if (m_we[i] && m_addr[i] == a) return m_data[i];
    return raw;
  endfunction

  function automatic logic exp_hit(input logic [AW-1:0] a);
    if (a == 0) return 1'b0;
    return (m_we[0] && m_addr[0] == a) || (m_we[1] && m_addr[1] == a);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_we[i] = 1'b0; m_addr[i] = '0; m_data[i] = '0;
    end
    m_cnt = 0;
  endfunction

  function automatic void set_ex(input logic we, input logic rd_sel, input int rt, input int rd,
                                 input logic [DW-1:0] res);
    EX_RegWrite = we; EX_RegDst = rd_sel;
    EX_rt = AW'(rt); EX_rd = AW'(rd); EX_result = res;
  endfunction

  // Advance the model by one edge using the current inputs, then step the DUT.
  task automatic tick();
    logic [AW-1:0] dst;
    dst = EX_RegDst ? EX_rd : EX_rt;
    if (!hold && (exp_hit(ID_rs) || exp_hit(ID_rt)) && m_cnt < 32'hFFFF) m_cnt++;
    if (!hold) begin
      m_we[1] = m_we[0]; m_addr[1] = m_addr[0]; m_data[1] = m_data[0];
    end
    if (flush) begin
      m_we[0] = 1'b0; m_addr[0] = '0; m_data[0] = '0;
    end else if (!hold) begin
      m_we[0] = EX_RegWrite && (dst != 0); m_addr[0] = dst; m_data[0] = EX_result;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    set_ex(1'b1, 1'b1, 0, 7, 32'h1111_0007);
    tick();
    set_ex(1'b1, 1'b1, 0, 6, 32'h1111_0006);
    tick();
    total++;
    if (WB_RegWrite !== 1'b1 || WB_waddr !== 5'd7) begin
      bad++; $display("FAIL reset_preload: we=%0b addr=%0d expected we=1 addr=7", WB_RegWrite, WB_waddr);
    end
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    total++;
    if (WB_RegWrite !== 1'b0 || WB_waddr !== '0 || WB_wdata !== '0) begin
      bad++; $display("FAIL reset_async: we=%0b addr=%0d data=%h expected 0/0/0", WB_RegWrite, WB_waddr, WB_wdata);
    end
    set_ex(1'b0, 1'b0, 0, 0, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (WB_RegWrite !== 1'b0) begin
        bad++; $display("FAIL reset_no_write: cycle %0d we=%0b expected 0", i, WB_RegWrite);
      end
    end
  endtask

  task automatic test_latency();
    set_ex(1'b1, 1'b1, 2, 8, 32'h1234);
    tick();
    set_ex(1'b1, 1'b0, 9, 3, 32'h5678);
    total++;
    if (WB_RegWrite !== 1'b0) begin
      bad++; $display("FAIL latency_early: we=%0b expected 0 after one edge", WB_RegWrite);
    end
    tick();
    set_ex(1'b0, 1'b0, 0, 0, '0);
    total++;
    if (WB_RegWrite !== 1'b1 || WB_waddr !== 5'd8 || WB_wdata !== 32'h1234) begin
      bad++; $display("FAIL latency_rd: we=%0b addr=%0d data=%h expected 1/8/1234", WB_RegWrite, WB_waddr, WB_wdata);
    end
    tick();
    total++;
    if (WB_RegWrite !== 1'b1 || WB_waddr !== 5'd9 || WB_wdata !== 32'h5678) begin
      bad++; $display("FAIL latency_rt: we=%0b addr=%0d data=%h expected 1/9/5678", WB_RegWrite, WB_waddr, WB_wdata);
    end
    tick();
    tick();
  endtask

  task automatic test_fwd_priority();
    ID_rs = 5'd5; ID_rdata1 = '0; ID_rt = 5'd5; ID_rdata2 = 32'hFFFF_0000;
    set_ex(1'b1, 1'b1, 0, 5, 32'hAAAA);
    tick();
    total++;
    if (ID_rdata1_fwd !== 32'hAAAA) begin
      bad++; $display("FAIL fwd_mem_single: got %h expected 0000aaaa", ID_rdata1_fwd);
    end
    set_ex(1'b1, 1'b1, 0, 5, 32'hBBBB);
    tick();
    set_ex(1'b0, 1'b0, 0, 0, '0);
    total++;
    if (ID_rdata1_fwd !== 32'hBBBB || ID_rdata2_fwd !== 32'hBBBB) begin
      bad++; $display("FAIL fwd_mem_priority: rs=%h rt=%h expected 0000bbbb", ID_rdata1_fwd, ID_rdata2_fwd);
    end
    tick();
    total++;
    if (ID_rdata1_fwd !== 32'hBBBB) begin
      bad++; $display("FAIL fwd_wb: got %h expected 0000bbbb", ID_rdata1_fwd);
    end
    tick();
    total++;
    if (ID_rdata2_fwd !== 32'hFFFF_0000) begin
      bad++; $display("FAIL fwd_none: got %h expected ffff0000", ID_rdata2_fwd);
    end
  endtask

  task automatic test_reg_zero();
    ID_rs = 5'd0; ID_rdata1 = '0; ID_rt = 5'd0; ID_rdata2 = 32'h42;
    set_ex(1'b1, 1'b1, 4, 0, 32'hDEAD);
    tick();
    set_ex(1'b0, 1'b0, 0, 0, '0);
    total++;
    if (ID_rdata1_fwd !== '0 || ID_rdata2_fwd !== 32'h42) begin
      bad++; $display("FAIL zero_fwd: rs=%h rt=%h expected 0/42", ID_rdata1_fwd, ID_rdata2_fwd);
    end
    tick();
    total++;
    if (WB_RegWrite !== 1'b0) begin
      bad++; $display("FAIL zero_write: we=%0b addr=%0d expected no write", WB_RegWrite, WB_waddr);
    end
  endtask

  task automatic test_flush_hold();
    ID_rs = 5'd3; ID_rdata1 = 32'h0303; ID_rt = 5'd4; ID_rdata2 = 32'h0404;
    set_ex(1'b1, 1'b1, 0, 4, 32'h66);
    tick();
    set_ex(1'b1, 1'b1, 0, 3, 32'h77);
    tick();
    set_ex(1'b1, 1'b1, 0, 12, 32'h99);
    hold = 1'b1; flush = 1'b1;
    tick();
    hold = 1'b0; flush = 1'b0;
    set_ex(1'b0, 1'b0, 0, 0, '0);
    total++;
    if (WB_RegWrite !== 1'b1 || WB_waddr !== 5'd4 || WB_wdata !== 32'h66) begin
      bad++; $display("FAIL flush_hold_wb: we=%0b addr=%0d data=%h expected 1/4/66", WB_RegWrite, WB_waddr, WB_wdata);
    end
    total++;
    if (ID_rdata1_fwd !== 32'h0303 || ID_rdata2_fwd !== 32'h66) begin
      bad++; $display("FAIL flush_hold_fwd: rs=%h rt=%h expected 0303/66", ID_rdata1_fwd, ID_rdata2_fwd);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if (WB_RegWrite === 1'b1 && (WB_waddr === 5'd3 || WB_waddr === 5'd12)) begin
        bad++; $display("FAIL flush_no_r3: cycle %0d addr=%0d was written, expected bubble", i, WB_waddr);
      end
    end
  endtask

`ifdef FWD_COUNT_EN
  task automatic test_fwd_count();
    int unsigned base;
    set_ex(1'b0, 1'b0, 0, 0, '0);
    tick(); tick(); tick();
    base = m_cnt;
    ID_rs = 5'd10; ID_rt = 5'd0;
    set_ex(1'b1, 1'b1, 0, 10, 32'hA);
    tick();
    set_ex(1'b0, 1'b0, 0, 0, '0);
    tick();
    hold = 1'b1;
    tick();
    hold = 1'b0;
    tick();
    ID_rs = 5'd0;
    tick();
    total++;
    if (32'(fwd_count) !== base + 2) begin
      bad++; $display("FAIL fwd_count: got %0d expected %0d", fwd_count, base + 2);
    end
  endtask
`endif

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      EX_RegWrite = ($urandom_range(0, 3) != 0);
      EX_RegDst   = 1'($urandom);
      EX_rt       = AW'($urandom_range(0, 7));
      EX_rd       = AW'($urandom_range(0, 7));
      EX_result   = $urandom;
      hold        = ($urandom_range(0, 7) == 0);
      flush       = ($urandom_range(0, 7) == 0);
      ID_rs       = AW'($urandom_range(0, 7));
      ID_rt       = AW'($urandom_range(0, 7));
      ID_rdata1   = $urandom;
      ID_rdata2   = $urandom;
      #1;
      total++;
      if (ID_rdata1_fwd !== exp_fwd(ID_rs, ID_rdata1) || ID_rdata2_fwd !== exp_fwd(ID_rt, ID_rdata2)) begin
        bad++; $display("FAIL rand_fwd: iter %0d rs=%0d got %h exp %h rt=%0d got %h exp %h", n, ID_rs,
                        ID_rdata1_fwd, exp_fwd(ID_rs, ID_rdata1), ID_rt, ID_rdata2_fwd, exp_fwd(ID_rt, ID_rdata2));
      end
      tick();
      total++;
      if (WB_RegWrite !== m_we[1] || WB_waddr !== m_addr[1] || WB_wdata !== m_data[1]) begin
        bad++; $display("FAIL rand_wb: iter %0d got %0b/%0d/%h exp %0b/%0d/%h", n, WB_RegWrite, WB_waddr,
                        WB_wdata, m_we[1], m_addr[1], m_data[1]);
      end
`ifdef FWD_COUNT_EN
      total++;
      if (32'(fwd_count) !== m_cnt) begin
        bad++; $display("FAIL rand_count: iter %0d got %0d exp %0d", n, fwd_count, m_cnt);
      end
`endif
    end
    hold = 1'b0; flush = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    hold = 1'b0; flush = 1'b0;
    set_ex(1'b0, 1'b0, 0, 0, '0);
    ID_rs = '0; ID_rt = '0; ID_rdata1 = '0; ID_rdata2 = '0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    total++;
    if (WB_RegWrite !== 1'b0 || WB_waddr !== '0 || WB_wdata !== '0) begin
      bad++; $display("FAIL reset_state: we=%0b addr=%0d data=%h expected 0/0/0", WB_RegWrite, WB_waddr, WB_wdata);
    end
    rst_n = 1'b1;
    test_latency();
    test_fwd_priority();
    test_reg_zero();
    test_flush_hold();
`ifdef FWD_COUNT_EN
    test_fwd_count();
`endif
    test_random();
    test_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
